rst_seq_gen: RTL and testbench

- Synchronous reset generator and sequencer. It is the producing end of the reset interface that downstream reset synchronizers consume.
- Stretches a system reset or a single-cycle software reset request into a minimum-width pulse.
- Releases NUM_OUT downstream reset lines in a fixed order, index 0 first, with a programmable gap between releases.
- Sits in the top-level clock domain. Its outputs feed per-subsystem resets and per-domain synchronizer inputs.

---
 rtl/rst_seq_gen_pkg.sv | 23 ++
 rtl/rst_seq_gen_btn.sv | 64 ++++++
 rtl/rst_seq_gen.sv | 160 ++++++++++++++++
 tb/tb_rst_seq_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_gen_pkg.sv
// Shared definitions for the reset sequencer.
//   state_e   : sequencer state encoding (ST_HOLD, ST_RELEASE, ST_IDLE)
//   cnt_width : width of a counter that must reach max(a, b) without wrapping
//   idx_width : width of an index over n items, never less than one bit
package rst_seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_IDLE    = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_gen_btn.sv
// Push-button front end for the reset sequencer.
// A 2-FF synchronizer feeds a debouncer that accepts a new level only after
// DEBOUNCE_CYCLES consecutive equal samples; a one-cycle pulse marks each
// accepted rising edge. Latency from a btn edge to the cycle in which the
// pulse is sampled downstream is 2 + DEBOUNCE_CYCLES.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, clears all state (level = 0)
//   btn  : asynchronous push-button input
//   rise : registered one-cycle pulse on a debounced rising edge
module btn_debounce
  import rst_seq_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES, 0);
  localparam logic [CntW-1:0] LastCnt = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rise_q, rise_d;

  // cnt_q counts consecutive samples that disagree with the accepted level;
  // the DEBOUNCE_CYCLES-th such sample flips the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LastCnt) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/rst_seq_gen.sv
// Reset generator and sequencer.
// Holds all NUM_OUT reset lines high for HOLD_CYCLES after the origin edge
// (reset release, or req sampled while idle), then releases them one at a
// time, bit 0 first, STAGE_CYCLES apart. Requests during a running sequence
// are dropped. All outputs are registered.
// Optional build macro RST_SEQ_GEN_BTN_DEBOUNCE_EN adds the btn input, whose
// debounced rising edge acts like req.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset, restarts the sequence from HOLD
//   req     : software reset request (pulse or level)
//   btn     : push-button reset (only with RST_SEQ_GEN_BTN_DEBOUNCE_EN)
//   rst_out : sequenced active-high resets, bit 0 released first
//   busy    : high while any rst_out bit is asserted
//   done    : one-cycle pulse in the cycle after the final release
module rst_seq_gen
  import rst_seq_gen_pkg::*;
#(
  parameter int unsigned NUM_OUT         = 3,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned STAGE_CYCLES    = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
`ifdef RST_SEQ_GEN_BTN_DEBOUNCE_EN
  input  logic               btn,
`endif
  output logic [NUM_OUT-1:0] rst_out,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CntW = cnt_width(HOLD_CYCLES, STAGE_CYCLES);
  localparam int unsigned IdxW = idx_width(NUM_OUT);

  localparam logic [CntW-1:0] CntMax   = '1;
  localparam logic [CntW-1:0] HoldCnt  = CntW'(HOLD_CYCLES);
  localparam logic [CntW-1:0] StageCnt = CntW'(STAGE_CYCLES);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_OUT - 1);

  if (NUM_OUT == 0 || HOLD_CYCLES == 0 || STAGE_CYCLES == 0 || DEBOUNCE_CYCLES == 0)
  begin : g_bad_param
    $error("rst_seq_gen: parameters must all be at least 1");
  end

  logic req_eff;

`ifdef RST_SEQ_GEN_BTN_DEBOUNCE_EN
  logic btn_req;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk (clk),
    .rst (rst),
    .btn (btn),
    .rise(btn_req)
  );

  assign req_eff = req | btn_req;
`else
  assign req_eff = req;
`endif

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]    stage_q, stage_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // cnt_q holds the number of edges since the last origin or release, so a
  // release fires when it equals HOLD_CYCLES or STAGE_CYCLES. Loading 1 on
  // the origin/release edge keeps req-started and reset-started timing equal.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    stage_d   = stage_q;
    rst_out_d = rst_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_HOLD: begin
        if (cnt_q == HoldCnt) begin
          rst_out_d[0] = 1'b0;
          cnt_d        = CntW'(1);
          if (NUM_OUT == 1) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
            stage_d = IdxW'(1);
          end
        end
      end

      ST_RELEASE: begin
        if (cnt_q == StageCnt) begin
          for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (stage_q == IdxW'(i)) rst_out_d[i] = 1'b0;
          end
          cnt_d = CntW'(1);
          if (stage_q == LastIdx) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stage_d = stage_q + IdxW'(1);
          end
        end
      end

      ST_IDLE: begin
        cnt_d = cnt_q;
        if (req_eff) begin
          state_d   = ST_HOLD;
          cnt_d     = CntW'(1);
          stage_d   = '0;
          rst_out_d = '1;
          busy_d    = 1'b1;
        end
      end

      default: begin
        state_d   = ST_HOLD;
        cnt_d     = '0;
        stage_d   = '0;
        rst_out_d = '1;
        busy_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      stage_q   <= '0;
      rst_out_q <= '1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rst_out = rst_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Self-checking bench for rst_seq_gen.
// DUT A: NUM_OUT=3, HOLD=4, STAGE=2 (power-up, software request, ignored
// requests, reset mid-sequence, optional button debounce).
// DUT B: NUM_OUT=1, HOLD=1 (degenerate case, req held high, rst beats req).
// Expected outputs come from a timing model driven by the origin edge and
// pass through a per-DUT scoreboard queue; fixed constants at key edges add
// direct checks.
module tb_rst_seq_gen;

  localparam int unsigned NA = 3, HA = 4, SA = 2;
  localparam int unsigned NB = 1, HB = 1, SB = 1;
  localparam int unsigned DB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, req_a, rst_b, req_b;
  logic [NA-1:0] rst_out_a;
  logic [NB-1:0] rst_out_b;
  logic          busy_a, done_a, busy_b, done_b;
`ifdef RST_SEQ_GEN_BTN_DEBOUNCE_EN
  logic          btn_a;
`endif

  rst_seq_gen #(
    .NUM_OUT(NA), .HOLD_CYCLES(HA), .STAGE_CYCLES(SA), .DEBOUNCE_CYCLES(DB)
  ) u_dut_a (
    .clk    (clk),
    .rst    (rst_a),
    .req    (req_a),
`ifdef RST_SEQ_GEN_BTN_DEBOUNCE_EN
    .btn    (btn_a),
`endif
    .rst_out(rst_out_a),
    .busy   (busy_a),
    .done   (done_a)
  );

  rst_seq_gen #(
    .NUM_OUT(NB), .HOLD_CYCLES(HB), .STAGE_CYCLES(SB), .DEBOUNCE_CYCLES(DB)
  ) u_dut_b (
    .clk    (clk),
    .rst    (rst_b),
    .req    (req_b),
`ifdef RST_SEQ_GEN_BTN_DEBOUNCE_EN
    .btn    (1'b0),
`endif
    .rst_out(rst_out_b),
    .busy   (busy_b),
    .done   (done_b)
  );

  typedef struct packed {
    logic [2:0] rst_out;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_fails  = 0;

  // Model state per DUT: in reset, running (t = edges since origin), or idle.
  bit m_rst[2];
  bit m_run[2];
  int m_t[2];

  task automatic model_step(input int id, input int n, input int h, input int s,
                            input bit r, input bit q, output exp_t e);
    int tend = h + (n - 1) * s;
    e = '0;
    if (r) begin
      m_rst[id] = 1'b1;
      m_run[id] = 1'b0;
    end else if (m_rst[id]) begin
      m_rst[id] = 1'b0;
      m_run[id] = 1'b1;
      m_t[id]   = 0;
    end else if (m_run[id]) begin
      m_t[id]++;
    end else if (q) begin
      m_run[id] = 1'b1;
      m_t[id]   = 0;
    end
    if (m_rst[id]) begin
      for (int i = 0; i < n; i++) e.rst_out[i] = 1'b1;
      e.busy = 1'b1;
    end else if (m_run[id]) begin
      for (int i = 0; i < n; i++) e.rst_out[i] = (m_t[id] < h + i * s);
      e.busy = |e.rst_out;
      if (m_t[id] == tend) begin
        e.done    = 1'b1;
        m_run[id] = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Drive one edge worth of inputs, let the edge happen, then score both DUTs.
  task automatic cycle(input int e, input bit ra, input bit qa, input bit rb, input bit qb,
                       input bit ba, input bit qa_btn);
    exp_t ea, eb, xa, xb;
    rst_a = ra;
    req_a = qa;
    rst_b = rb;
    req_b = qb;
`ifdef RST_SEQ_GEN_BTN_DEBOUNCE_EN
    btn_a = ba;
`else
    if (ba) $display("note: btn stimulus skipped at edge %0d (feature not built)", e);
`endif
    @(posedge clk);
    model_step(0, NA, HA, SA, ra, qa | qa_btn, ea);
    q_a.push_back(ea);
    model_step(1, NB, HB, SB, rb, qb, eb);
    q_b.push_back(eb);
    #1;
    xa = q_a.pop_front();
    xb = q_b.pop_front();
    check($sformatf("A.rst_out@%0d", e), rst_out_a, xa.rst_out);
    check($sformatf("A.busy@%0d", e), {2'b00, busy_a}, {2'b00, xa.busy});
    check($sformatf("A.done@%0d", e), {2'b00, done_a}, {2'b00, xa.done});
    check($sformatf("B.rst_out@%0d", e), {2'b00, rst_out_b}, xb.rst_out);
    check($sformatf("B.busy@%0d", e), {2'b00, busy_b}, {2'b00, xb.busy});
    check($sformatf("B.done@%0d", e), {2'b00, done_b}, {2'b00, xb.done});
  endtask

  initial begin
    bit ra, qa, rb, qb, ba, qbtn;
    for (int e = -3; e < 130; e++) begin
      // DUT A: power-up, req at 20 with ignored reqs at 22/25, req at 40,
      // rst (with req) at 46 while rst_out=110, ignored req at 47.
      ra = (e < 0) || (e == 46);
      qa = (e == 20) || (e == 22) || (e == 25) || (e == 40) || (e == 46) || (e == 47);
      // DUT B: req held high over two windows, rst together with req at 12.
      rb = (e < 0) || (e == 12);
      qb = (e >= 5 && e < 15) || (e >= 60 && e < 70);
      // Button: 5-cycle glitch, then 20-cycle press rising at edge 100.
      ba = 1'b0;
      qbtn = 1'b0;
`ifdef RST_SEQ_GEN_BTN_DEBOUNCE_EN
      ba   = (e >= 80 && e <= 84) || (e >= 100 && e <= 119);
      qbtn = (e == 100 + 2 + DB);
`endif
      cycle(e, ra, qa, rb, qb, ba, qbtn);

      // Fixed-value checks at edges called out by the test plan.
      case (e)
        -1: begin
          check("A.reset.rst_out", rst_out_a, 3'b111);
          check("A.reset.busy", {2'b00, busy_a}, 3'b001);
          check("A.reset.done", {2'b00, done_a}, 3'b000);
        end
        1: begin
          check("B.first.rst_out", {2'b00, rst_out_b}, 3'b000);
          check("B.first.done", {2'b00, done_b}, 3'b001);
        end
        3:  check("A.hold", rst_out_a, 3'b111);
        4:  check("A.rel0", rst_out_a, 3'b110);
        5:  check("B.req_level.rst_out", {2'b00, rst_out_b}, 3'b001);
        6: begin
          check("A.rel1", rst_out_a, 3'b100);
          check("B.b2b.done6", {2'b00, done_b}, 3'b001);
        end
        8: begin
          check("A.rel2", rst_out_a, 3'b000);
          check("A.done", {2'b00, done_a}, 3'b001);
          check("B.b2b.done8", {2'b00, done_b}, 3'b001);
        end
        9: begin
          check("A.done_once", {2'b00, done_a}, 3'b000);
          check("A.idle_busy", {2'b00, busy_a}, 3'b000);
        end
        12: check("B.rst_wins", {2'b00, rst_out_b}, 3'b001);
        14: check("B.after_rst.done", {2'b00, done_b}, 3'b001);
        20: check("A.swreq", rst_out_a, 3'b111);
        24: check("A.swreq.rel0", rst_out_a, 3'b110);
        26: check("A.swreq.rel1", rst_out_a, 3'b100);
        28: check("A.swreq.done", {2'b00, done_a}, 3'b001);
        44: check("A.mid.rel0", rst_out_a, 3'b110);
        46: check("A.mid.rst", rst_out_a, 3'b111);
        51: check("A.mid.restart_rel0", rst_out_a, 3'b110);
        54: check("A.mid.no_early_done", {2'b00, done_a}, 3'b000);
        55: check("A.mid.done", {2'b00, done_a}, 3'b001);
        90: check("A.glitch_ignored", {2'b00, busy_a}, 3'b000);
        default: ;
      endcase
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
